// File: rtl/car_pkg.sv
// car_pkg: shared state encoding, code width and parameter defaults for password entry
package car_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT, LOCKED} state_e;
  localparam int PW_W = 4;
  localparam int DEF_DEBOUNCE = 16;
  localparam int DEF_TIMEOUT = 1000;
  localparam int DEF_MAX_TRIES = 3;
  localparam int DEF_LOCK = 5000;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus stability counter; single-cycle accept per press
module key_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic acc
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] DONE = CW'(CYCLES);
  logic s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  // counter parks at DONE so a held key fires only once until it is released
  always_comb begin
    acc = s2_q && cnt_q == LAST;
    cnt_d = !s2_q ? '0 : (cnt_q == DONE ? cnt_q : cnt_q + 1'b1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= key;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/car_pw_entry.sv
// car_pw_entry: collects a 4-bit code from bit-keys, presents it with a strobe,
// and enforces inter-key timeout and attempt-limit lockout.
module car_pw_entry import car_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT,
  parameter int MAX_TRIES       = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES     = DEF_LOCK
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arm,
  input  logic            key_zero,
  input  logic            key_one,
  input  logic            key_clear,
  input  logic            pw_fail,
  output logic [PW_W-1:0] pw,
  output logic            pw_valid,
  output logic [2:0]      bit_count,
  output logic            locked
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int RW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_TRIES);
  logic acc_z, acc_o, acc_c, bz, bo, idle;
  logic [PW_W-1:0] nxt;
  state_e state_q, state_d;
  logic [PW_W-1:0] shift_q, shift_d, pw_q, pw_d;
  logic pw_valid_q, pw_valid_d, locked_q, locked_d;
  logic [2:0] bit_count_q, bit_count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [RW-1:0] tries_q, tries_d;
  logic [1:0] win_q, win_d;
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_zero (.clk(clk), .rst_n(rst_n), .key(key_zero), .acc(acc_z));
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_one (.clk(clk), .rst_n(rst_n), .key(key_one), .acc(acc_o));
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clear (.clk(clk), .rst_n(rst_n), .key(key_clear), .acc(acc_c));
  always_comb begin
    bz = acc_z & ~acc_o;
    bo = acc_o & ~acc_z;
    nxt = {shift_q[PW_W-2:0], bo};
    state_d = state_q;
    shift_d = shift_q;
    pw_d = pw_q;
    pw_valid_d = 1'b0;
    bit_count_d = bit_count_q;
    tmo_d = tmo_q;
    lock_d = '0;
    locked_d = 1'b0;
    idle = 1'b0;
    tries_d = (pw_fail && tries_q != MAX_R) ? tries_q + 1'b1 : tries_q;
    // win counts the two cycles after a presentation in which a fail may still arrive
    win_d = (win_q == 2'd0 || pw_fail) ? 2'd0 : win_q - 2'd1;
    if (win_q == 2'd1 && !pw_fail) tries_d = '0;
    case (state_q)
      IDLE: if (arm && (bz || bo) && !acc_c) begin
        state_d = COLLECT;
        shift_d = nxt;
        bit_count_d = 3'd1;
        tmo_d = TW'(1);
      end
      COLLECT: if (acc_c || !arm || (!(bz || bo) && tmo_q == TMO_LAST)) idle = 1'b1;
      else if (bz || bo) begin
        shift_d = nxt;
        bit_count_d = bit_count_q + 3'd1;
        tmo_d = TW'(1);
        if (bit_count_q == 3'(PW_W - 1)) begin
          state_d = PRESENT;
          pw_d = nxt;
          pw_valid_d = 1'b1;
        end
      end else tmo_d = tmo_q + 1'b1;
      PRESENT: begin
        idle = 1'b1;
        win_d = pw_fail ? 2'd0 : 2'd2;
      end
      LOCKED: if (lock_q == LOCK_LAST) begin
        idle = 1'b1;
        tries_d = '0;
      end else begin
        locked_d = 1'b1;
        lock_d = lock_q + 1'b1;
      end
    endcase
    if (idle) begin
      state_d = IDLE;
      shift_d = '0;
      bit_count_d = '0;
    end
    // reaching the try limit overrides any entry activity in the same cycle
    if (state_q != LOCKED && tries_d == MAX_R) begin
      state_d = LOCKED;
      shift_d = '0;
      bit_count_d = '0;
      pw_d = pw_q;
      pw_valid_d = 1'b0;
      locked_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      pw_q <= '0;
      pw_valid_q <= 1'b0;
      bit_count_q <= '0;
      locked_q <= 1'b0;
      tmo_q <= '0;
      lock_q <= '0;
      tries_q <= '0;
      win_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pw_q <= pw_d;
      pw_valid_q <= pw_valid_d;
      bit_count_q <= bit_count_d;
      locked_q <= locked_d;
      tmo_q <= tmo_d;
      lock_q <= lock_d;
      tries_q <= tries_d;
      win_q <= win_d;
    end
  assign pw = pw_q;
  assign pw_valid = pw_valid_q;
  assign bit_count = bit_count_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_car_pw_entry.sv
// tb_car_pw_entry: directed checks of entry, debounce, timeout, clear, lockout, reset and arm
module tb_car_pw_entry;
  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0;
  logic key_zero = 1'b0, key_one = 1'b0, key_clear = 1'b0, pw_fail = 1'b0;
  logic [3:0] pw;
  logic pw_valid, locked;
  logic [2:0] bit_count;
  int total = 0, bad = 0;
  int vcnt = 0, lock_len = 0;
  logic [3:0] last_pw = '0;
  logic [2:0] bc_at_valid = '0, bc_after_valid = '0;
  logic pv_d1 = 1'b0, pv_prev = 1'b0, fail_mode = 1'b0, fail_prev = 1'b0, lock_after = 1'b0;

  car_pw_entry #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50), .MAX_TRIES(3), .LOCK_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .key_zero(key_zero), .key_one(key_one),
    .key_clear(key_clear), .pw_fail(pw_fail), .pw(pw), .pw_valid(pw_valid),
    .bit_count(bit_count), .locked(locked)
  );

  always #5 clk = ~clk;

  // observer and fail responder: answers a presentation with pw_fail one cycle later
  always @(negedge clk) begin
    if (pv_prev) bc_after_valid = bit_count;
    if (pw_valid) begin
      vcnt++;
      last_pw = pw;
      bc_at_valid = bit_count;
    end
    pv_prev = pw_valid;
    if (fail_prev) lock_after = locked;
    fail_prev = pw_fail;
    if (locked) lock_len++;
    pw_fail = fail_mode && pv_d1;
    pv_d1 = pw_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic z, input logic o, input logic c);
    key_zero = z;
    key_one = o;
    key_clear = c;
    tick(10);
    key_zero = 1'b0;
    key_one = 1'b0;
    key_clear = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int v0;
    do_reset();
    chk("rst_pw", pw, 4'b0000);
    chk("rst_valid", pw_valid, 0);
    chk("rst_bc", bit_count, 0);
    chk("rst_locked", locked, 0);

    arm = 1'b1;
    press(1, 0, 0); chk("basic_bc1", bit_count, 1);
    press(1, 0, 0); chk("basic_bc2", bit_count, 2);
    press(1, 0, 0); chk("basic_bc3", bit_count, 3);
    press(0, 1, 0);
    chk("basic_vcnt", vcnt, 1);
    chk("basic_pw", last_pw, 4'b0001);
    chk("basic_bc4", bc_at_valid, 4);
    chk("basic_bc_after", bc_after_valid, 0);
    chk("basic_bc_end", bit_count, 0);

    repeat (5) begin
      key_one = 1'b1; tick(2);
      key_one = 1'b0; tick(2);
    end
    chk("bounce_none", bit_count, 0);
    press(0, 1, 0);
    chk("bounce_one", bit_count, 1);
    press(0, 0, 1);
    chk("bounce_clear", bit_count, 0);

    press(0, 1, 0);
    press(1, 0, 0);
    chk("tmo_bc2", bit_count, 2);
    tick(60);
    chk("tmo_idle", bit_count, 0);
    v0 = vcnt;
    repeat (4) press(0, 1, 0);
    chk("tmo_vcnt", vcnt, v0 + 1);
    chk("tmo_pw", last_pw, 4'b1111);

    v0 = vcnt;
    press(0, 1, 0); press(1, 0, 0); press(0, 1, 0);
    chk("clr_bc3", bit_count, 3);
    press(0, 0, 1);
    chk("clr_bc0", bit_count, 0);
    chk("clr_novalid", vcnt, v0);
    press(0, 1, 0);
    press(1, 1, 0);
    chk("both_keys", bit_count, 1);
    press(0, 1, 1);
    chk("clear_wins", bit_count, 0);

    fail_mode = 1'b1;
    repeat (2) repeat (4) press(1, 0, 0);
    chk("lock_pre", locked, 0);
    lock_len = 0;
    repeat (4) press(1, 0, 0);
    fail_mode = 1'b0;
    chk("lock_next_cycle", lock_after, 1);
    chk("lock_on", locked, 1);
    press(0, 1, 0);
    chk("lock_ignore", bit_count, 0);
    for (int i = 0; i < 300 && locked; i++) tick(1);
    chk("lock_fall", locked, 0);
    chk("lock_len", lock_len, 100);
    v0 = vcnt;
    press(0, 1, 0); press(1, 0, 0); press(0, 1, 0); press(1, 0, 0);
    chk("post_lock_vcnt", vcnt, v0 + 1);
    chk("post_lock_pw", last_pw, 4'b1010);
    tick(4);
    chk("post_lock_unlocked", locked, 0);

    press(0, 1, 0); press(1, 0, 0);
    chk("mid_rst_bc2", bit_count, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bc", bit_count, 0);
    chk("mid_rst_pw", pw, 4'b0000);
    chk("mid_rst_valid", pw_valid, 0);
    chk("mid_rst_locked", locked, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    v0 = vcnt;
    press(0, 1, 0); press(0, 1, 0);
    chk("arm_bc2", bit_count, 2);
    arm = 1'b0;
    tick(2);
    chk("arm_drop", bit_count, 0);
    press(0, 1, 0); press(0, 1, 0);
    chk("arm_low_ignore", bit_count, 0);
    arm = 1'b1;
    press(1, 0, 0); press(0, 1, 0);
    chk("arm_fresh", bit_count, 2);
    chk("arm_novalid", vcnt, v0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/car_pw_entry.md
# car_pw_entry

Password-entry front end for the car-park gate controller. It collects a 4-bit code from two bit-keys (0 and 1) on the driver's keypad, one bit per press, and presents the code on `pw` with a one-cycle `pw_valid` strobe to the password-check FSM directly downstream. It enforces an inter-key timeout and an attempt limit with timed lockout, using `pw_fail` fed back from the checker.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive synchronized-high cycles before a key press is accepted.
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed between accepted bits before a partial entry is discarded.
- `MAX_TRIES`, 3: failed attempts allowed before lockout.
- `LOCK_CYCLES`, 5000: lockout duration.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `arm`, in, 1: car present at the front sensor; level-sensitive; entry is accepted only while high.
- `key_zero`, in, 1: raw asynchronous pushbutton, enters bit 0.
- `key_one`, in, 1: raw asynchronous pushbutton, enters bit 1.
- `key_clear`, in, 1: raw asynchronous pushbutton, discards the partial entry.
- `pw_fail`, in, 1: one-cycle pulse from the checker marking the last presented code as wrong.
- `pw`, out, 4: assembled code, MSB entered first; held until the next presentation.
- `pw_valid`, out, 1: one-cycle strobe; `pw` is valid in the same cycle.
- `bit_count`, out, 3: bits entered so far (0–4), for the keypad display.
- `locked`, out, 1: high during lockout.

## Operation
- All three keys pass through a 2-flop synchronizer and then a debouncer.
- A key is accepted once, on the cycle its synchronized level has been high for `DEBOUNCE_CYCLES` consecutive cycles. It must then return low for at least 1 synchronized cycle before it can be accepted again.
- State machine:
  - IDLE: entry cleared, `bit_count`=0. Goes to COLLECT on an accepted bit-key while `arm`=1. That first bit is shifted in.
  - COLLECT: each accepted bit-key gives `shift = {shift[2:0], bit}` and `bit_count+1`.
    - On the 4th bit, go to PRESENT.
    - If `key_clear` is accepted or `arm` falls, go to IDLE.
    - Timeout counter resets on each accepted bit; reaching `TIMEOUT_CYCLES` goes to IDLE.
  - PRESENT: `pw` is loaded from the shift register and `pw_valid`=1 for exactly one cycle, then the block returns to IDLE.
  - LOCKED: all keys are ignored and `locked`=1. After `LOCK_CYCLES` cycles the block goes to IDLE and the try counter clears.
- Try counter:
  - `pw_fail` increments it, saturating at `MAX_TRIES`.
  - Reaching `MAX_TRIES` forces LOCKED from any state and discards any partial entry.
  - A presentation not followed by `pw_fail` within 2 cycles clears the counter (accepted code).
- Simultaneous events:
  - `key_zero` and `key_one` accepted in the same cycle: both are ignored and no bit is entered.
  - `key_clear` accepted in the same cycle as a bit-key: clear wins.
  - `pw_fail` in the same cycle as a bit acceptance: the lockout check wins.
- Reset values: `pw`=4'b0000, `pw_valid`=0, `bit_count`=0, `locked`=0. State is IDLE and all counters are 0.
- Reset asserted mid-entry or mid-lockout discards everything immediately.

## Timing
- Key edge to acceptance: 2 sync cycles + `DEBOUNCE_CYCLES`.
- 4th acceptance in cycle N: `pw_valid`=1 and `pw` updated in cycle N+1. `bit_count` reads 4 in cycle N+1 and 0 in N+2.
- `pw_fail` in cycle M with the count reaching `MAX_TRIES`: `locked`=1 in M+1. `locked` falls at M+1+`LOCK_CYCLES`.
- Timeout: the last acceptance at cycle T and no further keys gives IDLE at T+`TIMEOUT_CYCLES`.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Package `car_pkg`:
  - state enum IDLE/COLLECT/PRESENT/LOCKED.
  - `PW_W`=4, shared with the downstream checker.
  - parameter defaults.
- Sub-module `key_debounce`: synchronizer, stability counter and single-shot accept pulse. Instantiated three times.
- Top: FSM, shift register, timeout, try and lock counters.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=50, `MAX_TRIES`=3, `LOCK_CYCLES`=100.
- Basic entry: `arm`=1, press 0,0,0,1, each held 10 cycles → single `pw_valid` with `pw`=4'b0001, `bit_count` steps 1..4 and then 0.
- Bounce filtering: `key_one` toggled every 2 cycles for 20 cycles, then held high 10 cycles → exactly one bit accepted, `bit_count`=1.
- Timeout: enter 1,0, then idle 60 cycles, then enter 1,1,1,1 → `pw`=4'b1111, not 4'b1011.
- Clear and simultaneity:
  - `key_clear` after 3 bits → `bit_count`=0, no `pw_valid`.
  - `key_zero` and `key_one` accepted in the same cycle → `bit_count` unchanged.
- Lockout: three presentations, each answered with `pw_fail` → `locked`=1 the cycle after the 3rd fail, keys ignored for 100 cycles, then `locked`=0 and a fresh entry succeeds.
- Reset and arm: `rst_n` low after 2 bits → all outputs zero immediately. `arm` low during entry → IDLE, no `pw_valid`.
